tcam_cfg_ctrl: RTL and testbench

- iomem-bus slave that stages one TCAM entry (key, mask, action) in CPU-visible registers.
- On command, sequences the registered write strobes into the TCAM and action table.
- Sits between the picosoc iomem bus (address window 0x04xx_xxxx) and the tcam_wr_* / action_wr_* inputs of the match pipeline.
- Firmware writes the staging registers and then sets GO. It polls BUSY, or it may simply rely on the fixed sequence length.

---
 rtl/tcam_cfg_ctrl_if.sv | 19 +
 rtl/tcam_cfg_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_tcam_cfg_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_cfg_ctrl_if.sv
// picosoc iomem bus bundle between the CPU (master) and the TCAM staging block (slave).
interface tcam_cfg_ctrl_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/tcam_cfg_ctrl.sv
// Stages one TCAM entry (key, mask, action) behind the iomem bus and sequences its write strobes.
// Define TCAM_CFG_CLR_EN to build the CLR_ALL table-wipe walk; otherwise CLR_ALL is ignored.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for GO / GO_DEF / CLR_ALL
// S_WR_KEY  | key-plane write of the staged entry
// S_WR_MASK | mask-plane write of the staged entry
// S_WR_ACT  | action-table write, bumps COUNT
// S_WR_DEF  | default-action write, bumps COUNT
// S_CLR_KEY | wipe: key plane of entry clr_idx <- 0
// S_CLR_MASK| wipe: mask plane of entry clr_idx <- all ones
// S_CLR_ACT | wipe: action of entry clr_idx <- 0, advance clr_idx
module tcam_cfg_ctrl #(
    parameter int          KEY_W    = 48,
    parameter int          IDX_W    = 5,
    parameter int          ACTION_W = 16,
    parameter logic [7:0]  BASE_HI  = 8'h04
) (
    input  logic                 clk,
    input  logic                 resetn,
    tcam_cfg_ctrl_if.slave       bus,
    output logic                 tcam_wr_en,
    output logic                 tcam_wr_is_mask,
    output logic [IDX_W-1:0]     tcam_wr_addr,
    output logic [KEY_W-1:0]     tcam_wr_data,
    output logic                 action_wr_en,
    output logic [IDX_W-1:0]     action_wr_addr,
    output logic [ACTION_W-1:0]  action_wr_data,
    output logic                 action_wr_default,
    output logic [ACTION_W-1:0]  action_default_data,
    output logic                 busy
);
    localparam int KHI_W = KEY_W - 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_KEY,
        S_WR_MASK,
        S_WR_ACT,
        S_WR_DEF
`ifdef TCAM_CFG_CLR_EN
        ,
        S_CLR_KEY,
        S_CLR_MASK,
        S_CLR_ACT
`endif
    } state_t;

    state_t state, state_d;

    logic                ready_q;
    logic [31:0]         rdata_q;
    logic [IDX_W-1:0]    index_q;
    logic [31:0]         key_lo_q;
    logic [KHI_W-1:0]    key_hi_q;
    logic [31:0]         mask_lo_q;
    logic [KHI_W-1:0]    mask_hi_q;
    logic [ACTION_W-1:0] action_q;
    logic [15:0]         count_q, count_d;
    logic                err_q;

    logic                tcam_wr_en_d, tcam_wr_is_mask_d;
    logic [IDX_W-1:0]    tcam_wr_addr_d;
    logic [KEY_W-1:0]    tcam_wr_data_d;
    logic                action_wr_en_d, action_wr_default_d;
    logic [IDX_W-1:0]    action_wr_addr_d;
    logic [ACTION_W-1:0] action_wr_data_d, action_default_data_d;

`ifdef TCAM_CFG_CLR_EN
    logic [IDX_W-1:0]    clr_idx, clr_idx_d;
    logic                cmd_clr;
`endif

    logic        sel, wr, busy_w, ctrl_wr, stage_off, stage_wr;
    logic [2:0]  off;
    logic [31:0] ctrl_wd, rd_mux;
    logic        cmd_go, cmd_def, cmd_err;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    // ready gates sel so every request is taken exactly once, with a one-cycle ack
    assign sel       = bus.iomem_valid && (bus.iomem_addr[31:24] == BASE_HI) && !ready_q;
    assign wr        = sel && (bus.iomem_wstrb != 4'b0000);
    assign off       = bus.iomem_addr[4:2];
    assign busy_w    = (state != S_IDLE);
    assign ctrl_wr   = wr && (off == 3'd0);
    assign stage_off = (off >= 3'd1) && (off <= 3'd6);
    assign stage_wr  = wr && stage_off && !busy_w;
    assign ctrl_wd   = lane_merge(32'h0, bus.iomem_wdata, bus.iomem_wstrb);

    logic unused_bits;
    assign unused_bits = ^{bus.iomem_addr[23:5], bus.iomem_addr[1:0], ctrl_wd};

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign busy            = busy_w;

    // command decode with conflict and busy-drop resolution
    always_comb begin
        cmd_go  = 1'b0;
        cmd_def = 1'b0;
        cmd_err = 1'b0;
`ifdef TCAM_CFG_CLR_EN
        cmd_clr = 1'b0;
        if (ctrl_wr) begin
            if (busy_w)
                cmd_err = ctrl_wd[0] | ctrl_wd[1] | ctrl_wd[2];
            else if (ctrl_wd[2]) begin
                cmd_clr = 1'b1;
                cmd_err = ctrl_wd[0] | ctrl_wd[1];
            end else if (ctrl_wd[0]) begin
                cmd_go  = 1'b1;
                cmd_err = ctrl_wd[1];
            end else if (ctrl_wd[1])
                cmd_def = 1'b1;
        end
`else
        if (ctrl_wr) begin
            if (busy_w)
                cmd_err = ctrl_wd[0] | ctrl_wd[1];
            else if (ctrl_wd[0]) begin
                cmd_go  = 1'b1;
                cmd_err = ctrl_wd[1];
            end else if (ctrl_wd[1])
                cmd_def = 1'b1;
        end
`endif
        if (wr && stage_off && busy_w)
            cmd_err = 1'b1;
    end

    always_comb begin
        rd_mux = 32'h0;
        case (off)
            3'd0: rd_mux = {count_q, 14'd0, err_q, busy_w};
            3'd1: rd_mux = 32'(index_q);
            3'd2: rd_mux = key_lo_q;
            3'd3: rd_mux = 32'(key_hi_q);
            3'd4: rd_mux = mask_lo_q;
            3'd5: rd_mux = 32'(mask_hi_q);
            3'd6: rd_mux = 32'(action_q);
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ready_q <= sel;
            rdata_q <= sel ? rd_mux : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_q   <= '0;
            key_lo_q  <= '0;
            key_hi_q  <= '0;
            mask_lo_q <= '0;
            mask_hi_q <= '0;
            action_q  <= '0;
        end else if (stage_wr) begin
            case (off)
                3'd1: index_q   <= IDX_W'(lane_merge(32'(index_q), bus.iomem_wdata, bus.iomem_wstrb));
                3'd2: key_lo_q  <= lane_merge(key_lo_q, bus.iomem_wdata, bus.iomem_wstrb);
                3'd3: key_hi_q  <= KHI_W'(lane_merge(32'(key_hi_q), bus.iomem_wdata, bus.iomem_wstrb));
                3'd4: mask_lo_q <= lane_merge(mask_lo_q, bus.iomem_wdata, bus.iomem_wstrb);
                3'd5: mask_hi_q <= KHI_W'(lane_merge(32'(mask_hi_q), bus.iomem_wdata, bus.iomem_wstrb));
                3'd6: action_q  <= ACTION_W'(lane_merge(32'(action_q), bus.iomem_wdata, bus.iomem_wstrb));
                default: ;
            endcase
        end
    end

    // a set in the same write as ERR_CLR keeps the error visible
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            err_q <= 1'b0;
        else if (cmd_err)
            err_q <= 1'b1;
        else if (ctrl_wr && ctrl_wd[8])
            err_q <= 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            count_q <= 16'h0;
`ifdef TCAM_CFG_CLR_EN
            clr_idx <= '0;
`endif
        end else begin
            state   <= state_d;
            count_q <= count_d;
`ifdef TCAM_CFG_CLR_EN
            clr_idx <= clr_idx_d;
`endif
        end
    end

    // strobes are computed from the current state and registered, so they trail the state by one cycle
    always_comb begin
        state_d               = state;
        count_d               = count_q;
        tcam_wr_en_d          = 1'b0;
        tcam_wr_is_mask_d     = 1'b0;
        tcam_wr_addr_d        = '0;
        tcam_wr_data_d        = '0;
        action_wr_en_d        = 1'b0;
        action_wr_addr_d      = '0;
        action_wr_data_d      = '0;
        action_wr_default_d   = 1'b0;
        action_default_data_d = action_default_data;
`ifdef TCAM_CFG_CLR_EN
        clr_idx_d             = clr_idx;
`endif
        case (state)
            S_IDLE: begin
`ifdef TCAM_CFG_CLR_EN
                if (cmd_clr) begin
                    state_d   = S_CLR_KEY;
                    clr_idx_d = '0;
                end else
`endif
                if (cmd_go)
                    state_d = S_WR_KEY;
                else if (cmd_def)
                    state_d = S_WR_DEF;
            end
            S_WR_KEY: begin
                tcam_wr_en_d   = 1'b1;
                tcam_wr_addr_d = index_q;
                tcam_wr_data_d = {key_hi_q, key_lo_q};
                state_d        = S_WR_MASK;
            end
            S_WR_MASK: begin
                tcam_wr_en_d      = 1'b1;
                tcam_wr_is_mask_d = 1'b1;
                tcam_wr_addr_d    = index_q;
                tcam_wr_data_d    = {mask_hi_q, mask_lo_q};
                state_d           = S_WR_ACT;
            end
            S_WR_ACT: begin
                action_wr_en_d   = 1'b1;
                action_wr_addr_d = index_q;
                action_wr_data_d = action_q;
                count_d          = count_q + 16'd1;
                state_d          = S_IDLE;
            end
            S_WR_DEF: begin
                action_wr_default_d   = 1'b1;
                action_default_data_d = action_q;
                count_d               = count_q + 16'd1;
                state_d               = S_IDLE;
            end
`ifdef TCAM_CFG_CLR_EN
            S_CLR_KEY: begin
                tcam_wr_en_d   = 1'b1;
                tcam_wr_addr_d = clr_idx;
                state_d        = S_CLR_MASK;
            end
            S_CLR_MASK: begin
                tcam_wr_en_d      = 1'b1;
                tcam_wr_is_mask_d = 1'b1;
                tcam_wr_addr_d    = clr_idx;
                tcam_wr_data_d    = '1;
                state_d           = S_CLR_ACT;
            end
            S_CLR_ACT: begin
                action_wr_en_d   = 1'b1;
                action_wr_addr_d = clr_idx;
                if (clr_idx == '1)
                    state_d = S_IDLE;
                else begin
                    clr_idx_d = clr_idx + IDX_W'(1);
                    state_d   = S_CLR_KEY;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcam_wr_en          <= 1'b0;
            tcam_wr_is_mask     <= 1'b0;
            tcam_wr_addr        <= '0;
            tcam_wr_data        <= '0;
            action_wr_en        <= 1'b0;
            action_wr_addr      <= '0;
            action_wr_data      <= '0;
            action_wr_default   <= 1'b0;
            action_default_data <= '0;
        end else begin
            tcam_wr_en          <= tcam_wr_en_d;
            tcam_wr_is_mask     <= tcam_wr_is_mask_d;
            tcam_wr_addr        <= tcam_wr_addr_d;
            tcam_wr_data        <= tcam_wr_data_d;
            action_wr_en        <= action_wr_en_d;
            action_wr_addr      <= action_wr_addr_d;
            action_wr_data      <= action_wr_data_d;
            action_wr_default   <= action_wr_default_d;
            action_default_data <= action_default_data_d;
        end
    end
endmodule

// File: tb/tb_tcam_cfg_ctrl.sv
// Directed bench for tcam_cfg_ctrl: commit, default action, busy drop, conflict, clear, reset abort.
module tb_tcam_cfg_ctrl;
    localparam int KEY_W    = 48;
    localparam int IDX_W    = 2;
    localparam int ACTION_W = 16;
    localparam logic [31:0] BASE = 32'h0400_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00, A_INDEX = BASE + 32'h04,
                            A_KLO = BASE + 32'h08, A_KHI = BASE + 32'h0C,
                            A_MLO = BASE + 32'h10, A_MHI = BASE + 32'h14,
                            A_ACT = BASE + 32'h18, A_RSV = BASE + 32'h1C;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tcam_cfg_ctrl_if bus();

    logic                tcam_wr_en, tcam_wr_is_mask;
    logic [IDX_W-1:0]    tcam_wr_addr;
    logic [KEY_W-1:0]    tcam_wr_data;
    logic                action_wr_en, action_wr_default, busy;
    logic [IDX_W-1:0]    action_wr_addr;
    logic [ACTION_W-1:0] action_wr_data, action_default_data;

    tcam_cfg_ctrl #(.KEY_W(KEY_W), .IDX_W(IDX_W), .ACTION_W(ACTION_W), .BASE_HI(8'h04)) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .tcam_wr_en(tcam_wr_en), .tcam_wr_is_mask(tcam_wr_is_mask),
        .tcam_wr_addr(tcam_wr_addr), .tcam_wr_data(tcam_wr_data),
        .action_wr_en(action_wr_en), .action_wr_addr(action_wr_addr),
        .action_wr_data(action_wr_data), .action_wr_default(action_wr_default),
        .action_default_data(action_default_data), .busy(busy)
    );

    int total = 0;
    int bad = 0;
    int n_key = 0, n_act = 0, n_def = 0;
    logic [KEY_W-1:0] last_key = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tcam_wr_en && !tcam_wr_is_mask) begin
            n_key++;
            last_key = tcam_wr_data;
        end
        if (action_wr_en) n_act++;
        if (action_wr_default) n_def++;
    end

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = a;
        bus.iomem_wdata = d;
        bus.iomem_wstrb = s;
        @(posedge clk);
        #1 chk("wr_ack", 64'(bus.iomem_ready), 64'd1);
        @(negedge clk);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = a;
        bus.iomem_wstrb = 4'h0;
        @(posedge clk);
        #1 chk("rd_ack", 64'(bus.iomem_ready), 64'd1);
        d = bus.iomem_rdata;
        @(negedge clk);
        bus.iomem_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        chk(tag, 64'(d), 64'(exp));
    endtask

    int sk, sa, sd;

    initial begin
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_tcam_en", 64'(tcam_wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(bus.iomem_ready), 64'd0);
        resetn = 1'b1;
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_klo", A_KLO, 32'h0);

        // staging registers, byte lanes, reserved, wrong base
        bus_wr(A_INDEX, 32'hFFFF_FFFF, 4'hF);
        rd_chk("index_trunc", A_INDEX, 32'h3);
        bus_wr(A_KLO, 32'hDEAD_BEEF, 4'hF);
        bus_wr(A_KLO, 32'hAABB_CCDD, 4'b0010);
        rd_chk("klo_lane", A_KLO, 32'hDEAD_CCEF);
        bus_wr(A_KLO, 32'hDEAD_BEEF, 4'hF);
        bus_wr(A_KHI, 32'hFFFF_1234, 4'hF);
        rd_chk("khi_trunc", A_KHI, 32'h1234);
        bus_wr(A_MLO, 32'hFFFF_FFFF, 4'hF);
        bus_wr(A_MHI, 32'h0000_FFFF, 4'hF);
        bus_wr(A_ACT, 32'h0000_00A5, 4'hF);
        rd_chk("act_rd", A_ACT, 32'hA5);
        bus_wr(A_RSV, 32'h1234_5678, 4'hF);
        rd_chk("rsv_rd", A_RSV, 32'h0);
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h0500_0008;
        bus.iomem_wdata = 32'h0;
        bus.iomem_wstrb = 4'hF;
        @(posedge clk);
        #1 chk("other_base_noack", 64'(bus.iomem_ready), 64'd0);
        @(negedge clk);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        rd_chk("other_base_kept", A_KLO, 32'hDEAD_BEEF);

        // entry commit
        bus_wr(A_CTRL, 32'h1, 4'hF);
        chk("commit_busy", 64'(busy), 64'd1);
        chk("commit_nolead", 64'(tcam_wr_en), 64'd0);
        @(negedge clk);
        chk("key_en", 64'(tcam_wr_en), 64'd1);
        chk("key_plane", 64'(tcam_wr_is_mask), 64'd0);
        chk("key_addr", 64'(tcam_wr_addr), 64'd3);
        chk("key_data", 64'(tcam_wr_data), 64'h1234_DEAD_BEEF);
        @(negedge clk);
        chk("mask_en", 64'(tcam_wr_en), 64'd1);
        chk("mask_plane", 64'(tcam_wr_is_mask), 64'd1);
        chk("mask_data", 64'(tcam_wr_data), 64'hFFFF_FFFF_FFFF);
        @(negedge clk);
        chk("act_tcam_off", 64'(tcam_wr_en), 64'd0);
        chk("act_en", 64'(action_wr_en), 64'd1);
        chk("act_addr", 64'(action_wr_addr), 64'd3);
        chk("act_data", 64'(action_wr_data), 64'hA5);
        @(negedge clk);
        chk("after_act_off", 64'(action_wr_en), 64'd0);
        rd_chk("commit_count", A_CTRL, 32'h0001_0000);

        // default action
        bus_wr(A_ACT, 32'h42, 4'hF);
        bus_wr(A_CTRL, 32'h2, 4'hF);
        @(negedge clk);
        chk("def_strobe", 64'(action_wr_default), 64'd1);
        chk("def_data", 64'(action_default_data), 64'h42);
        chk("def_no_act", 64'(action_wr_en), 64'd0);
        @(negedge clk);
        chk("def_drop", 64'(action_wr_default), 64'd0);
        chk("def_hold", 64'(action_default_data), 64'h42);
        rd_chk("def_count", A_CTRL, 32'h0002_0000);

        // busy protection
        bus_wr(A_CTRL, 32'h1, 4'hF);
        bus_wr(A_KLO, 32'h1111_1111, 4'hF);
        repeat (3) @(negedge clk);
        chk("busy_key_orig", 64'(last_key), 64'h1234_DEAD_BEEF);
        rd_chk("busy_err", A_CTRL, 32'h0003_0002);
        rd_chk("busy_klo_kept", A_KLO, 32'hDEAD_BEEF);
        bus_wr(A_CTRL, 32'h100, 4'b0010);
        rd_chk("err_clr", A_CTRL, 32'h0003_0000);

        // BUSY visible on read mid-sequence
        bus_wr(A_CTRL, 32'h1, 4'hF);
        rd_chk("busy_read", A_CTRL, 32'h0003_0001);
        repeat (3) @(negedge clk);

        // conflict GO+GO_DEF
        sa = n_act; sd = n_def;
        bus_wr(A_CTRL, 32'h3, 4'hF);
        repeat (5) @(negedge clk);
        chk("conf_act", 64'(n_act), 64'(sa + 1));
        chk("conf_def", 64'(n_def), 64'(sd));
        rd_chk("conf_err", A_CTRL, 32'h0005_0002);
        bus_wr(A_CTRL, 32'h100, 4'hF);

        // clear all
`ifdef TCAM_CFG_CLR_EN
        bus_wr(A_CTRL, 32'h4, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("clr_key_en", 64'({tcam_wr_en, tcam_wr_is_mask}), 64'b10);
            chk("clr_key_addr", 64'(tcam_wr_addr), 64'(i));
            chk("clr_key_data", 64'(tcam_wr_data), 64'h0);
            @(negedge clk);
            chk("clr_mask_en", 64'({tcam_wr_en, tcam_wr_is_mask}), 64'b11);
            chk("clr_mask_data", 64'(tcam_wr_data), 64'hFFFF_FFFF_FFFF);
            @(negedge clk);
            chk("clr_act_en", 64'({action_wr_en, tcam_wr_en}), 64'b10);
            chk("clr_act_addr", 64'(action_wr_addr), 64'(i));
            chk("clr_act_data", 64'(action_wr_data), 64'h0);
        end
        @(negedge clk);
        chk("clr_done_idle", 64'({busy, tcam_wr_en, action_wr_en}), 64'b000);
`else
        sk = n_key; sa = n_act;
        bus_wr(A_CTRL, 32'h4, 4'hF);
        chk("clr_off_busy", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        chk("clr_off_key", 64'(n_key), 64'(sk));
        chk("clr_off_act", 64'(n_act), 64'(sa));
`endif
        rd_chk("clr_ctrl", A_CTRL, 32'h0005_0000);
        rd_chk("clr_index", A_INDEX, 32'h3);

        // reset mid-commit
        sa = n_act;
        bus_wr(A_CTRL, 32'h1, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_mask", 64'({tcam_wr_en, tcam_wr_is_mask}), 64'b11);
        resetn = 1'b0;
        #1;
        chk("rst_mid_outs", 64'({tcam_wr_en, tcam_wr_is_mask, action_wr_en, action_wr_default, busy}), 64'd0);
        chk("rst_mid_data", 64'(tcam_wr_data), 64'h0);
        chk("rst_mid_defdata", 64'(action_default_data), 64'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_noact", 64'(n_act), 64'(sa));
        rd_chk("rst_mid_count", A_CTRL, 32'h0);
        rd_chk("rst_mid_klo", A_KLO, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
